// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate decoder feeding a DEPTH-entry FIFO.
// Ports: clk, rst (async, active-high), flush, in_valid/in_ready, in_instr,
//   in_pc; out_valid/out_ready, out_instr, out_pc, out_imm, out_fmt,
//   out_illegal, count. Define IMM_GEN_ZICSR_EN for CSR zimm decode (fmt 6).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_fmt,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] F_R = 3'd0;
  localparam logic [2:0] F_I = 3'd1;
  localparam logic [2:0] F_S = 3'd2;
  localparam logic [2:0] F_B = 3'd3;
  localparam logic [2:0] F_U = 3'd4;
  localparam logic [2:0] F_J = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
  localparam logic [2:0] F_Z = 3'd6;
`endif
  localparam logic [2:0] F_X = 3'd7;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } entry_t;

  logic [6:0]         op;
  logic signed [11:0] i12;
  logic signed [11:0] s12;
  logic signed [12:0] b13;
  logic signed [31:0] u32;
  logic signed [20:0] j21;
  logic [XLEN-1:0]    d_imm;
  logic [2:0]         d_fmt;
  entry_t             ent;

  // Opcode bits [1:0] are part of every match, so a non-32-bit
  // encoding falls through to the illegal default.
  assign op  = in_instr[6:0];
  assign i12 = in_instr[31:20];
  assign s12 = {in_instr[31:25], in_instr[11:7]};
  assign b13 = {in_instr[31], in_instr[7],
                in_instr[30:25], in_instr[11:8], 1'b0};
  assign u32 = {in_instr[31:12], 12'b0};
  assign j21 = {in_instr[31], in_instr[19:12],
                in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    d_fmt = F_X;
    d_imm = '0;
    unique case (1'b1)
      (op == OP_R): begin
        d_fmt = F_R;
      end
      (op == OP_IMM) || (op == OP_LD) || (op == OP_JLR): begin
        d_fmt = F_I;
        d_imm = XLEN'(i12);
      end
      (op == OP_ST): begin
        d_fmt = F_S;
        d_imm = XLEN'(s12);
      end
      (op == OP_BR): begin
        d_fmt = F_B;
        d_imm = XLEN'(b13);
      end
      (op == OP_LUI) || (op == OP_AUI): begin
        d_fmt = F_U;
        d_imm = XLEN'(u32);
      end
      (op == OP_JAL): begin
        d_fmt = F_J;
        d_imm = XLEN'(j21);
      end
`ifdef IMM_GEN_ZICSR_EN
      (op == OP_SYS) && in_instr[14]: begin
        d_fmt = F_Z;
        d_imm = XLEN'(in_instr[19:15]);
      end
      (op == OP_SYS) && !in_instr[14]: begin
        d_fmt = F_I;
        d_imm = XLEN'(i12);
      end
`else
      (op == OP_SYS): begin
        d_fmt = F_I;
        d_imm = XLEN'(i12);
      end
`endif
      default: begin
        d_fmt = F_X;
        d_imm = '0;
      end
    endcase
  end

  assign ent.instr = in_instr;
  assign ent.pc    = in_pc;
  assign ent.imm   = d_imm;
  assign ent.fmt   = d_fmt;
  assign ent.ill   = (d_fmt == F_X);

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            rdy;
  logic            push;
  logic            pop;

  assign push    = in_valid && rdy;
  assign pop     = out_valid && out_ready;
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      rdy <= 1'b0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      rdy <= 1'b1;
    end else begin
      wp  <= wp + AW'(push);
      rp  <= rp + AW'(pop);
      cnt <= cnt_nxt;
      rdy <= (cnt_nxt < CW'(DEPTH));
    end
  end

  // Payload storage needs no reset: it is only visible through
  // the count-gated output muxes below.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= ent;
  end

  assign head        = mem[rp];
  assign in_ready    = rdy;
  assign count       = cnt;
  assign out_valid   = (cnt != '0);
  assign out_instr   = out_valid ? head.instr : '0;
  assign out_pc      = out_valid ? head.pc    : '0;
  assign out_imm     = out_valid ? head.imm   : '0;
  assign out_fmt     = out_valid ? head.fmt   : '0;
  assign out_illegal = out_valid ? head.ill   : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe (XLEN 32 and 64, DEPTH 4).
// Honors IMM_GEN_ZICSR_EN for the CSR immediate expectations.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic [63:0] pc64;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [2:0]  out_fmt;
  logic [2:0]  count;

  logic        r64, v64, il64;
  logic [31:0] ins64;
  logic [63:0] pco64, imm64;
  logic [2:0]  fmt64;
  logic [2:0]  cnt64;

  int n_cmp = 0;
  int n_err = 0;

  assign pc64 = {32'h0, in_pc};

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .count(count)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_pc(pc64),
    .out_valid(v64), .out_ready(out_ready),
    .out_instr(ins64), .out_pc(pco64),
    .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(il64), .count(cnt64)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streaming push with out_ready high: the FIFO holds exactly the
  // entry pushed at this edge, so the head is always the new entry.
  task automatic stream(input string tag,
                        input logic [31:0] ins,
                        input logic [31:0] eimm,
                        input logic [2:0]  efmt,
                        input logic        eill);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_instr  = ins;
    tick();
    chk({tag, "_v"},   out_valid, 1'b1);
    chk({tag, "_imm"}, out_imm, eimm);
    chk({tag, "_fmt"}, out_fmt, efmt);
    chk({tag, "_ill"}, out_illegal, eill);
  endtask

  function automatic logic [31:0] addi_k(input int k);
    logic [11:0] imm;
    imm = 12'(k);
    return {imm, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  initial begin
    #1;
    chk("rst_rdy",  in_ready, 1'b0);
    chk("rst_vld",  out_valid, 1'b0);
    chk("rst_cnt",  count, 3'd0);
    chk("rst_imm",  out_imm, 32'h0);
    chk("rst_fmt",  out_fmt, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rdy_up", in_ready, 1'b1);
    chk("empty_vld", out_valid, 1'b0);

    in_valid = 1'b1;
    in_instr = 32'hFFF00093;
    in_pc    = 32'h100;
    tick();
    in_valid = 1'b0;
    chk("addi_v",   out_valid, 1'b1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_fmt", out_fmt, 3'd1);
    chk("addi_cnt", count, 3'd1);
    chk("addi_pc",  out_pc, 32'h100);
    chk("addi_ins", out_instr, 32'hFFF00093);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_cnt", count, 3'd0);
    chk("pop_vld", out_valid, 1'b0);

    stream("sw",   32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);
    stream("beq",  32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0);
    stream("lui",  32'h123450B7, 32'h12345000, 3'd4, 1'b0);
    chk("lui64", imm64, 64'h0000000012345000);
    stream("lui2", 32'h800000B7, 32'h80000000, 3'd4, 1'b0);
    chk("lui2_64", imm64, 64'hFFFFFFFF80000000);
    chk("lui2_f64", fmt64, 3'd4);
    stream("jal",  32'h8000006F, 32'hFFF00000, 3'd5, 1'b0);
    chk("jal64", imm64, 64'hFFFFFFFFFFF00000);
    stream("add",  32'h002081B3, 32'h0, 3'd0, 1'b0);
    stream("slli", 32'h01F09093, 32'h1F, 3'd1, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
    stream("csri", 32'h3050D073, 32'h1, 3'd6, 1'b0);
`else
    stream("csri", 32'h3050D073, 32'h305, 3'd1, 1'b0);
`endif
    stream("zero", 32'h00000000, 32'h0, 3'd7, 1'b1);
    stream("badop", 32'hFFFFFFFF, 32'h0, 3'd7, 1'b1);
    chk("bad_cnt", count, 3'd1);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("drain_cnt", count, 3'd0);
    chk("drain_imm", out_imm, 32'h0);

    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_instr = addi_k(k);
      tick();
    end
    chk("full_cnt", count, 3'd4);
    chk("full_rdy", in_ready, 1'b0);
    in_instr = addi_k(4);
    tick();
    chk("held_cnt", count, 3'd4);
    chk("held_rdy", in_ready, 1'b0);
    chk("held_head", out_imm, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop1_cnt", count, 3'd3);
    chk("pop1_rdy", in_ready, 1'b1);
    chk("pop1_head", out_imm, 32'h1);
    tick();
    chk("refill_cnt", count, 3'd4);
    chk("refill_rdy", in_ready, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("order%0d", i), out_imm, 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("order_cnt", count, 3'd0);

    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_instr = addi_k(8 + k);
      tick();
    end
    chk("pre_fl_cnt", count, 3'd3);
    flush    = 1'b1;
    in_instr = addi_k(99);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_cnt", count, 3'd0);
    chk("fl_vld", out_valid, 1'b0);
    chk("fl_rdy", in_ready, 1'b1);
    chk("fl_imm", out_imm, 32'h0);
    tick();
    chk("fl_absent", count, 3'd0);

    in_valid = 1'b1;
    in_instr = addi_k(5);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_cnt", count, 3'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cnt", count, 3'd0);
    chk("arst_vld", out_valid, 1'b0);
    chk("arst_rdy", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rerdy", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
